// File: rtl/data_sync_pkg.sv
// Shared types and default parameters for the DATA_SYNC source-side launcher.
package data_sync_pkg;

  // Launcher FSM encoding
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    RELEASE = 2'd2
  } state_e;

  localparam int DEF_BUS_WIDTH      = 8;
  localparam int DEF_NUM_STAGES     = 2;
  localparam int DEF_TIMEOUT_CYCLES = 64;

endpackage

// File: rtl/bit_sync.sv
// Single-bit multi-flop synchronizer; all stages reset to 0.
module bit_sync #(
  parameter int NUM_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic [NUM_STAGES-1:0] sync_q;

  // Shift the asynchronous input through the flop chain
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) sync_q <= '0;
    else       sync_q <= {sync_q[NUM_STAGES-2:0], d_i};
  end

  assign q_o = sync_q[NUM_STAGES-1];

endmodule

// File: rtl/data_sync_tx.sv
// Source-side launcher for DATA_SYNC: latches a word, holds it on unsync_bus
// and runs a 4-phase bus_enable/ack handshake so the word never changes while
// the destination may still be sampling it.
module data_sync_tx
  import data_sync_pkg::*;
#(
  parameter int BUS_WIDTH      = DEF_BUS_WIDTH,
  parameter int NUM_STAGES     = DEF_NUM_STAGES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [BUS_WIDTH-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  input  logic                 ack_async,
  output logic [BUS_WIDTH-1:0] unsync_bus,
  output logic                 bus_enable,
  output logic                 busy,
  output logic                 tx_done,
  output logic                 tx_error
);

  // Counter must hold 0..TIMEOUT_CYCLES; keep at least one bit when disabled
  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST =
    (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

  state_e               state_q;
  logic [BUS_WIDTH-1:0] bus_q;
  logic                 en_q;
  logic                 ready_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 err_q;
  logic                 timed_out_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [CNT_W-1:0]     cnt_d;
  logic                 ack_sync;
  logic                 timeout_hit;

  bit_sync #(
    .NUM_STAGES(NUM_STAGES)
  ) u_ack_sync (
    .clk_i(CLK),
    .rst_i(RST),
    .d_i  (ack_async),
    .q_o  (ack_sync)
  );

  // Saturating increment: the REQ age counter never wraps
  assign cnt_d       = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST);

  // Handshake FSM with all outputs registered
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= IDLE;
      bus_q       <= '0;
      en_q        <= 1'b0;
      ready_q     <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      timed_out_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (tx_valid && ready_q) begin
            bus_q       <= tx_data;
            en_q        <= 1'b1;
            ready_q     <= 1'b0;
            busy_q      <= 1'b1;
            cnt_q       <= '0;
            timed_out_q <= 1'b0;
            state_q     <= REQ;
          end
        end
        REQ: begin
          if (ack_sync) begin
            en_q    <= 1'b0;
            state_q <= RELEASE;
          end else if (timeout_hit) begin
            en_q        <= 1'b0;
            err_q       <= 1'b1;
            timed_out_q <= 1'b1;
            state_q     <= RELEASE;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        RELEASE: begin
          // Wait for the far side to drop ack before offering a new word
          if (!ack_sync) begin
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= ~timed_out_q;
            state_q <= IDLE;
          end
        end
        default: begin
          en_q    <= 1'b0;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign tx_ready   = ready_q;
  assign unsync_bus = bus_q;
  assign bus_enable = en_q;
  assign busy       = busy_q;
  assign tx_done    = done_q;
  assign tx_error   = err_q;

endmodule

// File: tb/tb_data_sync_tx.sv
// Bench for data_sync_tx: transaction-level reference model plus directed
// scenarios and a randomized responder/traffic phase.
module tb_data_sync_tx;

  localparam int BW = 8;
  localparam int NS = 2;
  localparam int TO = 8;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic [BW-1:0] tx_data = '0;
  logic          tx_valid = 1'b0;
  logic          ack_async = 1'b0;
  logic          tx_ready;
  logic [BW-1:0] unsync_bus;
  logic          bus_enable;
  logic          busy;
  logic          tx_done;
  logic          tx_error;

  data_sync_tx #(
    .BUS_WIDTH(BW), .NUM_STAGES(NS), .TIMEOUT_CYCLES(TO)
  ) dut (
    .CLK(CLK), .RST(RST), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .ack_async(ack_async), .unsync_bus(unsync_bus),
    .bus_enable(bus_enable), .busy(busy), .tx_done(tx_done), .tx_error(tx_error)
  );

  always #5 CLK = ~CLK;

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  int n_done = 0;
  int n_err = 0;

  always @(posedge CLK) cyc++;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
  endtask

  // Reference model: a transfer is idle / waiting for ack / waiting for ack
  // release. The ack seen at an edge is the ack_async value NS edges earlier.
  int            phase;
  logic [BW-1:0] m_bus;
  bit            m_done, m_err, m_timed;
  int            mcyc, t_acc;
  bit            ackhist[$];

  always @(posedge CLK or posedge RST) begin : model
    bit seen;
    if (RST) begin
      phase = 0; m_bus = '0; m_done = 0; m_err = 0; m_timed = 0;
      ackhist.delete();
      repeat (NS) ackhist.push_back(1'b0);
    end else begin
      seen = ackhist.pop_front();
      ackhist.push_back(ack_async);
      mcyc++;
      m_done = 0; m_err = 0;
      if (phase == 0) begin
        if (tx_valid) begin
          phase = 1; m_bus = tx_data; t_acc = mcyc; m_timed = 0;
        end
      end else if (phase == 1) begin
        if (seen) phase = 2;
        else if (TO != 0 && mcyc - t_acc == TO) begin
          phase = 2; m_err = 1; m_timed = 1;
        end
      end else if (!seen) begin
        phase = 0; m_done = !m_timed;
      end
    end
  end

  // Cycle-by-cycle compare against the model
  always @(negedge CLK) begin
    chk("unsync_bus", int'(unsync_bus), int'(m_bus));
    chk("bus_enable", int'(bus_enable), int'(phase == 1));
    chk("tx_ready",   int'(tx_ready),   int'(phase == 0));
    chk("busy",       int'(busy),       int'(phase != 0));
    chk("tx_done",    int'(tx_done),    int'(m_done));
    chk("tx_error",   int'(tx_error),   int'(m_err));
    chk("done_err_excl", int'(tx_done && tx_error), 0);
    if (tx_done)  n_done++;
    if (tx_error) n_err++;
  end

  // Destination-side responder: ack follows bus_enable with programmable delays
  bit resp_on = 0, rand_dly = 0, glitch_req = 0;
  int rise_dly = 3, fall_dly = 3, hi_cnt = 0, lo_cnt = 0, ack_rise_cyc = 0;

  always @(negedge CLK) begin
    if (RST) begin
      ack_async = 1'b0; hi_cnt = 0; lo_cnt = 0;
    end else if (glitch_req && !ack_async) begin
      glitch_req = 0;
      #1 ack_async = 1'b1;
      #2 ack_async = 1'b0;
    end else if (resp_on) begin
      if (!ack_async) begin
        if (!bus_enable) hi_cnt = 0;
        else if (hi_cnt >= rise_dly) begin
          ack_async = 1'b1; ack_rise_cyc = cyc; hi_cnt = 0;
        end else hi_cnt++;
      end else if (!bus_enable) begin
        if (lo_cnt >= fall_dly) begin
          ack_async = 1'b0; lo_cnt = 0;
          if (rand_dly) begin
            rise_dly = $urandom_range(0, 9);
            fall_dly = $urandom_range(0, 4);
          end
        end else lo_cnt++;
      end
    end
  end

  task automatic send(input logic [BW-1:0] d, input bit keep);
    tx_data = d; tx_valid = 1'b1;
    for (int i = 0; i < 60 && !tx_ready; i++) @(negedge CLK);
    chk("send_wait_ready", int'(tx_ready), 1);
    @(negedge CLK);
    if (!keep) tx_valid = 1'b0;
  endtask

  task automatic wait_en_low(input int lim);
    for (int i = 0; i < lim && bus_enable; i++) @(negedge CLK);
    chk("wait_en_low", int'(bus_enable), 0);
  endtask

  task automatic wait_ready(input int lim);
    for (int i = 0; i < lim && !tx_ready; i++) @(negedge CLK);
    chk("wait_ready", int'(tx_ready), 1);
  endtask

  initial begin
    int d0, e0, hc;

    // Reset state
    repeat (3) @(negedge CLK);
    chk("rst_ready", int'(tx_ready), 1);
    chk("rst_en",    int'(bus_enable), 0);
    chk("rst_bus",   int'(unsync_bus), 0);
    chk("rst_busy",  int'(busy), 0);
    RST = 1'b0;
    @(negedge CLK);

    // Single transfer
    resp_on = 1; rise_dly = 3; fall_dly = 3;
    d0 = n_done; e0 = n_err;
    send(8'hAB, 0);
    chk("single_en",    int'(bus_enable), 1);
    chk("single_bus",   int'(unsync_bus), 'hAB);
    chk("single_ready", int'(tx_ready), 0);
    wait_en_low(40);
    chk("en_fall_latency", cyc - ack_rise_cyc, NS + 1);
    wait_ready(40);
    @(negedge CLK);
    chk("single_done", n_done - d0, 1);
    chk("single_err",  n_err - e0, 0);

    // Back-to-back with tx_valid held high
    rise_dly = 1; fall_dly = 1; d0 = n_done;
    send(8'hAB, 1);
    send(8'hCD, 1);
    send(8'hEF, 0);
    chk("b2b_last_bus", int'(unsync_bus), 'hEF);
    wait_ready(60);
    @(negedge CLK);
    chk("b2b_done", n_done - d0, 3);

    // Busy interlock followed by timeout (no ack)
    resp_on = 0; d0 = n_done; e0 = n_err;
    send(8'h3C, 0);
    tx_data = 8'hFF; tx_valid = 1'b1; hc = 0;
    for (int i = 0; i < 40 && bus_enable; i++) begin
      hc++;
      if (hc == 3) tx_valid = 1'b0;
      @(negedge CLK);
    end
    tx_valid = 1'b0;
    chk("timeout_en_cycles", hc, TO);
    chk("interlock_bus", int'(unsync_bus), 'h3C);
    wait_ready(20);
    @(negedge CLK);
    chk("timeout_err",  n_err - e0, 1);
    chk("timeout_done", n_done - d0, 0);
    chk("idle_keeps_bus", int'(unsync_bus), 'h3C);

    // Mid-transfer reset
    d0 = n_done; e0 = n_err;
    send(8'h5A, 0);
    @(negedge CLK);
    #2 RST = 1'b1;
    #1;
    chk("midrst_en",    int'(bus_enable), 0);
    chk("midrst_bus",   int'(unsync_bus), 0);
    chk("midrst_ready", int'(tx_ready), 1);
    chk("midrst_busy",  int'(busy), 0);
    chk("midrst_pulse", int'(tx_done | tx_error), 0);
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    chk("midrst_no_pulses", (n_done - d0) + (n_err - e0), 0);
    resp_on = 1; rise_dly = 3; fall_dly = 3;
    send(8'h11, 0);
    wait_ready(40);
    @(negedge CLK);
    chk("after_rst_done", n_done - d0, 1);
    chk("after_rst_bus",  int'(unsync_bus), 'h11);

    // Sub-cycle ack glitches are never sampled
    resp_on = 0;
    send(8'h77, 0);
    repeat (2) begin glitch_req = 1; @(negedge CLK); end
    @(negedge CLK);
    chk("glitch_en",   int'(bus_enable), 1);
    chk("glitch_busy", int'(busy), 1);
    resp_on = 1; rise_dly = 0;
    wait_ready(40);

    // Randomized traffic, responder delays, glitches and resets
    rand_dly = 1;
    for (int i = 0; i < 2000; i++) begin
      @(negedge CLK);
      tx_valid = 1'($urandom_range(0, 1));
      tx_data  = 8'($urandom);
      if ($urandom_range(0, 29) == 0) glitch_req = 1;
      if ($urandom_range(0, 299) == 0) begin
        #2 RST = 1'b1;
        #1 chk("rand_rst_en", int'(bus_enable), 0);
        @(negedge CLK);
        RST = 1'b0;
      end
    end
    tx_valid = 1'b0;
    wait_ready(100);
    repeat (2) @(negedge CLK);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
